// File: rtl/switch_allocator_wh_pkg.sv
// Shared NoC port naming and the wormhole lock-entry record
// used by the switch allocator.
package params_noc;

  localparam int in_Port_Cnt = 5;
  localparam int LOCK_IDX_W  = 4;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    EAST  = 3'd2,
    SOUTH = 3'd3,
    WEST  = 3'd4
  } inout_Port;

  typedef struct packed {
    logic                  valid;
    logic [LOCK_IDX_W-1:0] in_idx;
    logic [LOCK_IDX_W-1:0] vc_idx;
  } lock_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: priority starts at ptr, which moves
// to winner+1 only when the caller confirms the grant.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          update_en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr;
  logic [IW:0]   s;
  logic [IW-1:0] k;

  // Scan from farthest to nearest so the nearest request wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    s   = '0;
    k   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      s = {1'b0, ptr} + (IW + 1)'(i);
      if (s >= (IW + 1)'(N)) s = s - (IW + 1)'(N);
      k = s[IW-1:0];
      if (req[k]) begin
        gnt    = '0;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (update_en && |req) begin
      ptr <= (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: rtl/switch_allocator_wh.sv
// Two-stage separable switch allocator (VC then output).
// SA_PKT_LOCK_EN adds wormhole locking of outputs.
module switch_allocator_wh
  import params_noc::*;
#(
  parameter int PORT_CNT = in_Port_Cnt,
  parameter int VC_NUM   = 4,
  localparam int SW = $clog2(PORT_CNT),
  localparam int VW = $clog2(VC_NUM)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic      [PORT_CNT-1:0][VC_NUM-1:0] request_in,
  input  inout_Port [PORT_CNT-1:0][VC_NUM-1:0] out_port_in,
  input  logic      [PORT_CNT-1:0][VC_NUM-1:0] tail_in,
  input  logic      [PORT_CNT-1:0]             out_ready_in,
  output logic      [PORT_CNT-1:0][VC_NUM-1:0] grant_o,
  output logic      [PORT_CNT-1:0][SW-1:0]     xbar_sel_o,
  output logic      [PORT_CNT-1:0]             xbar_vld_o
);

  logic [PORT_CNT-1:0][VC_NUM-1:0]   s1_req;
  logic [PORT_CNT-1:0][VC_NUM-1:0]   s1_gnt;
  logic [PORT_CNT-1:0][VW-1:0]       s1_idx;
  logic [PORT_CNT-1:0]               won;
  logic [PORT_CNT-1:0][PORT_CNT-1:0] s2_req;
  logic [PORT_CNT-1:0][PORT_CNT-1:0] s2_gnt;
  logic [PORT_CNT-1:0][SW-1:0]       s2_idx;

`ifdef SA_PKT_LOCK_EN
  lock_entry_t [PORT_CNT-1:0] lock_q;
  logic [PORT_CNT-1:0]         win_tail;
  logic [PORT_CNT-1:0][VW-1:0] win_vc;
`else
  logic unused_tail;
  assign unused_tail = ^tail_in;
`endif

  // A VC owning a lock on its target pre-empts its siblings.
  always_comb begin : s1_mask
    logic [VC_NUM-1:0] elig;
    logic [VC_NUM-1:0] own;
    inout_Port         t;
    s1_req = '0;
    for (int p = 0; p < PORT_CNT; p++) begin
      elig = '0;
      own  = '0;
      for (int v = 0; v < VC_NUM; v++) begin
        t = out_port_in[p][v];
        elig[v] = request_in[p][v] &&
                  (int'(t) < PORT_CNT) &&
                  out_ready_in[t];
`ifdef SA_PKT_LOCK_EN
        if (elig[v] && lock_q[t].valid) begin
          if (lock_q[t].in_idx == LOCK_IDX_W'(p) &&
              lock_q[t].vc_idx == LOCK_IDX_W'(v))
            own[v] = 1'b1;
          else
            elig[v] = 1'b0;
        end
`endif
      end
      s1_req[p] = (|own) ? own : elig;
    end
  end

  always_comb begin : s2_build
    inout_Port tgt;
    s2_req = '0;
    for (int p = 0; p < PORT_CNT; p++) begin
      tgt = out_port_in[p][s1_idx[p]];
      for (int o = 0; o < PORT_CNT; o++)
        s2_req[o][p] = (|s1_gnt[p]) && (int'(tgt) == o);
    end
  end

  always_comb begin
    won = '0;
    for (int o = 0; o < PORT_CNT; o++)
      won = won | s2_gnt[o];
  end

  for (genvar p = 0; p < PORT_CNT; p++) begin : g_s1
    rr_arbiter #(.N(VC_NUM)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (s1_req[p]),
      .update_en (won[p]),
      .gnt       (s1_gnt[p]),
      .idx       (s1_idx[p])
    );
  end

  for (genvar o = 0; o < PORT_CNT; o++) begin : g_s2
    rr_arbiter #(.N(PORT_CNT)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (s2_req[o]),
      .update_en (|s2_req[o]),
      .gnt       (s2_gnt[o]),
      .idx       (s2_idx[o])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_o    <= '0;
      xbar_sel_o <= '0;
      xbar_vld_o <= '0;
    end else begin
      for (int p = 0; p < PORT_CNT; p++)
        grant_o[p] <= won[p] ? s1_gnt[p] : '0;
      for (int o = 0; o < PORT_CNT; o++)
        xbar_vld_o[o] <= |s2_req[o];
      xbar_sel_o <= s2_idx;
    end
  end

`ifdef SA_PKT_LOCK_EN
  always_comb begin
    win_tail = '0;
    win_vc   = '0;
    for (int o = 0; o < PORT_CNT; o++)
      for (int p = 0; p < PORT_CNT; p++)
        if (s2_gnt[o][p]) begin
          win_tail[o] = tail_in[p][s1_idx[p]];
          win_vc[o]   = s1_idx[p];
        end
  end

  // Head/body grants (re)arm the lock; a tail grant frees it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q <= '0;
    end else begin
      for (int o = 0; o < PORT_CNT; o++)
        if (|s2_req[o]) begin
          if (win_tail[o]) begin
            lock_q[o].valid <= 1'b0;
          end else begin
            lock_q[o].valid  <= 1'b1;
            lock_q[o].in_idx <= LOCK_IDX_W'(s2_idx[o]);
            lock_q[o].vc_idx <= LOCK_IDX_W'(win_vc[o]);
          end
        end
    end
  end
`endif

endmodule

// File: tb/tb_switch_allocator_wh.sv
// Randomized and directed bench for switch_allocator_wh
// against a round-robin reference model.
module tb_switch_allocator_wh;
  import params_noc::*;

  localparam int P  = 5;
  localparam int V  = 4;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic      [P-1:0][V-1:0] request_in;
  inout_Port [P-1:0][V-1:0] out_port_in;
  logic      [P-1:0][V-1:0] tail_in;
  logic      [P-1:0]        out_ready_in;
  logic      [P-1:0][V-1:0] grant_o;
  logic      [P-1:0][SW-1:0] xbar_sel_o;
  logic      [P-1:0]        xbar_vld_o;

  int n_tests = 0;
  int n_fail  = 0;

  int ptr1[P];
  int ptr2[P];
  bit lv[P];
  int lp[P];
  int lvc[P];
  logic [P-1:0][V-1:0]  exp_gnt;
  logic [P-1:0][SW-1:0] exp_sel;
  logic [P-1:0]         exp_vld;

  always #5 clk = ~clk;

  switch_allocator_wh #(.PORT_CNT(P), .VC_NUM(V)) dut (
    .clk          (clk),
    .rst          (rst),
    .request_in   (request_in),
    .out_port_in  (out_port_in),
    .tail_in      (tail_in),
    .out_ready_in (out_ready_in),
    .grant_o      (grant_o),
    .xbar_sel_o   (xbar_sel_o),
    .xbar_vld_o   (xbar_vld_o)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [P-1:0][SW-1:0] sel_mask(
      input logic [P-1:0][SW-1:0] s, input logic [P-1:0] m);
    logic [P-1:0][SW-1:0] r;
    r = '0;
    for (int o = 0; o < P; o++) if (m[o]) r[o] = s[o];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < P; i++) begin
      ptr1[i] = 0; ptr2[i] = 0;
      lv[i] = 0; lp[i] = 0; lvc[i] = 0;
    end
  endtask

  // One allocation round computed from the current inputs.
  task automatic model_step();
    int w1[P];
    bit [V-1:0] cand, own;
    int t, v, p;
    bit ok;
    exp_gnt = '0; exp_sel = '0; exp_vld = '0;
    for (int q = 0; q < P; q++) begin
      w1[q] = -1; cand = '0; own = '0;
      for (int c = 0; c < V; c++) begin
        t  = int'(out_port_in[q][c]);
        ok = request_in[q][c] && t < P && out_ready_in[t];
`ifdef SA_PKT_LOCK_EN
        if (ok && lv[t]) begin
          if (lp[t] == q && lvc[t] == c) own[c] = 1;
          else ok = 0;
        end
`endif
        cand[c] = ok;
      end
      if (own != 0) cand = own;
      for (int i = 0; i < V; i++) begin
        v = (ptr1[q] + i) % V;
        if (cand[v]) begin w1[q] = v; break; end
      end
    end
    for (int o = 0; o < P; o++) begin
      for (int i = 0; i < P; i++) begin
        p = (ptr2[o] + i) % P;
        if (w1[p] >= 0 && int'(out_port_in[p][w1[p]]) == o) begin
          exp_gnt[p][w1[p]] = 1'b1;
          exp_sel[o] = SW'(p);
          exp_vld[o] = 1'b1;
          ptr2[o] = (p + 1) % P;
          ptr1[p] = (w1[p] + 1) % V;
`ifdef SA_PKT_LOCK_EN
          if (tail_in[p][w1[p]]) lv[o] = 0;
          else begin lv[o] = 1; lp[o] = p; lvc[o] = w1[p]; end
`endif
          break;
        end
      end
    end
  endtask

  // Called at a negedge with inputs already driven.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("grant", grant_o, exp_gnt);
    check("vld", xbar_vld_o, exp_vld);
    check("sel", sel_mask(xbar_sel_o, xbar_vld_o), exp_sel);
    @(negedge clk);
  endtask

  task automatic clear_in();
    request_in   = '0;
    tail_in      = '1;
    out_ready_in = '1;
    for (int p = 0; p < P; p++)
      for (int v = 0; v < V; v++) out_port_in[p][v] = LOCAL;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_grant", grant_o, 0);
    check("rst_vld", xbar_vld_o, 0);
    check("rst_sel", xbar_sel_o, 0);
    model_reset();
    rst = 1'b0;
  endtask

  initial begin
    int seq[6];
    int flit;
    clear_in();
    do_reset();

    // LOCAL: four VCs to EAST rotate VC0..VC3, VC0
    for (int v = 0; v < V; v++) begin
      request_in[0][v] = 1'b1;
      out_port_in[0][v] = EAST;
    end
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("local_vc_rr", grant_o[0], 4'b0001 << (i % 4));
    end

    // all inputs VC0 to EAST: input rotation, one grant at a time
    clear_in(); do_reset();
    for (int p = 0; p < P; p++) begin
      request_in[p][0] = 1'b1;
      out_port_in[p][0] = EAST;
    end
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("east_sel", xbar_sel_o[EAST], i % 5);
      check("east_one", $countones(grant_o), 1);
    end

    // NORTH stalled by credit: no grant, priority preserved
    clear_in(); do_reset();
    request_in[0][0] = 1'b1; out_port_in[0][0] = NORTH;
    request_in[2][1] = 1'b1; out_port_in[2][1] = NORTH;
    cycle();
    check("north_first", xbar_sel_o[NORTH], 0);
    out_ready_in[NORTH] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("north_stall", xbar_vld_o[NORTH], 0);
    end
    out_ready_in[NORTH] = 1'b1;
    cycle();
    check("north_resume", xbar_sel_o[NORTH], 2);

    // WEST VC2 3-flit packet vs SOUTH, both to EAST
`ifdef SA_PKT_LOCK_EN
    seq = '{4, 4, 4, 3, 3, 3};
`else
    seq = '{4, 3, 4, 3, 4, 3};
`endif
    clear_in(); do_reset();
    flit = 0;
    for (int c = 0; c < 6; c++) begin
      request_in[4][2] = (flit < 3);
      out_port_in[4][2] = EAST;
      tail_in[4][2] = (flit == 2);
      request_in[3][0] = (c >= 1);
      out_port_in[3][0] = EAST;
      tail_in[3][0] = 1'b1;
      cycle();
      check("wh_east", xbar_sel_o[EAST], seq[c]);
      if (grant_o[4][2]) flit++;
    end

    // random traffic with an asynchronous reset midway
    clear_in(); do_reset();
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        #2 rst = 1'b1;
        #1;
        check("async_grant", grant_o, 0);
        check("async_vld", xbar_vld_o, 0);
        check("async_sel", xbar_sel_o, 0);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
      end
      for (int p = 0; p < P; p++)
        for (int v = 0; v < V; v++) begin
          request_in[p][v] = 1'($urandom_range(0, 1));
          out_port_in[p][v] = inout_Port'($urandom_range(0, 4));
          tail_in[p][v] = ($urandom_range(0, 2) == 0);
        end
      out_ready_in = P'($urandom) | P'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_allocator_wh.md
SWITCH_ALLOCATOR_WH -- requirements
Module: switch_allocator_wh

Interface
REQ-001 SHALL have parameter PORT_CNT, default in_Port_Cnt (5), router port count.
REQ-002 SHALL have parameter VC_NUM, default 4, virtual channels per input port.
REQ-003 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port request_in, input, [PORT_CNT][VC_NUM]: VC v of input p has a flit ready.
REQ-006 SHALL have port out_port_in, input, [PORT_CNT][VC_NUM] of inout_Port: requested output per VC.
REQ-007 SHALL have port tail_in, input, [PORT_CNT][VC_NUM]: the requesting flit is a tail flit.
REQ-008 SHALL have port out_ready_in, input, [PORT_CNT]: output port has downstream credit.
REQ-009 SHALL have port grant_o, output, [PORT_CNT][VC_NUM]: registered grant, at most one-hot per input.
REQ-010 SHALL have port xbar_sel_o, output, [PORT_CNT][$clog2(PORT_CNT)]: input index driving each output.
REQ-011 SHALL have port xbar_vld_o, output, [PORT_CNT]: xbar_sel_o of that output is valid this cycle.

Function
REQ-012 Stage 1 SHALL round-robin per input among VCs with request_in=1, out_ready_in[target]=1, and target not locked to another (input,VC).
REQ-013 Stage 2 SHALL round-robin per output among inputs whose stage-1 winner targets it.
REQ-014 Latency: requests sampled at edge N SHALL give grant_o/xbar_* valid from edge N+1 for exactly one cycle.
REQ-015 Per cycle: at most one grant per input, at most one per output; grant_o[p][v] implies xbar_sel_o[out_port_in[p][v]]=p with valid=1.
REQ-016 A pointer SHALL advance to winner+1 modulo VC_NUM or PORT_CNT, wrapping to 0, only when its grant is issued.
REQ-017 A stage-1 winner that loses stage 2 SHALL NOT advance its input pointer.
REQ-018 Requests masked by out_ready_in=0 SHALL produce no grant and move no pointer.
REQ-019 No requests SHALL give grant_o=0 and xbar_vld_o=0 with all state held.
REQ-020 Combinational request-to-grant path SHALL not exist; grant_o, xbar_sel_o and xbar_vld_o are flops.

Reset
REQ-021 rst=1 SHALL asynchronously clear grant_o, xbar_sel_o, xbar_vld_o, all pointers (VC0/input0 highest priority) and all locks.
REQ-022 Reset mid-packet SHALL drop any lock; the first cycle after deassertion arbitrates from reset priority.

Configuration
REQ-023 Macro SA_PKT_LOCK_EN defined SHALL enable wormhole locking: granting a non-tail flit of (p,v) locks output o to (p,v).
REQ-024 With the lock held, only (p,v) SHALL be eligible for o, and input p stage 1 SHALL select v whenever v requests.
REQ-025 With the lock held, a cycle where (p,v) does not request or o is not ready SHALL leave o idle and keep the lock.
REQ-026 The lock SHALL clear on the edge that registers a grant to a tail flit of (p,v).
REQ-027 Without SA_PKT_LOCK_EN, no lock state SHALL exist and every flit SHALL arbitrate independently; tail_in is ignored.

Structure
REQ-028 inout_Port, in_Port_Cnt and a new lock-entry struct (valid, input index, VC index) SHALL live in package params_noc.
REQ-029 Sub-module rr_arbiter (parameter N; inputs req, update_en; output one-hot gnt and index) SHALL be used for both stages.
REQ-030 Instance count SHALL be PORT_CNT for stage 1 plus PORT_CNT for stage 2.

Verification
REQ-031 Reset: rst pulsed mid-traffic -> all outputs 0 asynchronously; after release, VC0 and input0 win first.
REQ-032 Input LOCAL, VCs 0-3 all request EAST every cycle, out_ready=1 -> grants VC0,1,2,3,0 on consecutive cycles.
REQ-033 All 5 inputs request EAST -> xbar_sel_o[EAST] cycles 0,1,2,3,4,0; never two grants to EAST in one cycle.
REQ-034 out_ready_in[NORTH]=0 for 3 cycles with NORTH requests -> no NORTH grant and pointers unchanged; then the grant resumes at the prior priority.
REQ-035 SA_PKT_LOCK_EN set: input WEST VC2 sends a 3-flit packet to EAST while SOUTH also requests EAST -> EAST serves only WEST VC2 until the tail, and SOUTH is granted the next cycle.
REQ-036 SA_PKT_LOCK_EN unset, same stimulus -> EAST alternates between WEST and SOUTH each cycle.
